// File: rtl/beat_note_timer.sv
// Note sequencer between song reader, beat generator and note player.
// Optional articulation gap in the final beat of a note: NOTE_GAP_EN.
module beat_note_timer #(
    parameter int PITCH_W = 6,
    parameter int DUR_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         play_state,
    input  logic               beat,
    input  logic               note_valid,
    output logic               note_ready,
    input  logic [PITCH_W-1:0] note_pitch,
    input  logic [DUR_W-1:0]   note_dur,
    input  logic               note_last,
    output logic               beat_en,
    output logic [PITCH_W-1:0] pitch_out,
    output logic               note_active,
    output logic               new_note,
    output logic [DUR_W-1:0]   beats_left,
    output logic               song_done
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

    state_t state, state_nxt;
    logic   last_q;
    logic   xfer;
    logic   keep;
    logic   counted;
    logic   final_beat;

    assign xfer       = note_valid & note_ready;
    assign keep       = (note_dur != '0);
    assign counted    = (state == PLAY) & beat & play_state[1];
    assign final_beat = counted & (beats_left == DUR_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        note_ready = 1'b0;
        beat_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (play_state[1]) state_nxt = FETCH;
            end
            FETCH: begin
                note_ready = 1'b1;
                if (xfer) begin
                    if (keep)           state_nxt = PLAY;
                    else if (note_last) state_nxt = DONE;
                end
            end
            PLAY: begin
                beat_en = play_state[1];
                if (final_beat) state_nxt = last_q ? DONE : FETCH;
            end
            DONE: begin
                if (!play_state[1]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pitch_out   <= '0;
            beats_left  <= '0;
            note_active <= 1'b0;
            new_note    <= 1'b0;
            song_done   <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            if (xfer && keep) begin
                pitch_out   <= note_pitch;
                beats_left  <= note_dur;
                last_q      <= note_last;
                new_note    <= 1'b1;
                note_active <= (note_pitch != '0);
            end
            if (xfer && !keep && note_last) song_done <= 1'b1;
            if (counted) begin
                if (final_beat) begin
                    beats_left  <= '0;
                    note_active <= 1'b0;
                    if (last_q) song_done <= 1'b1;
                end else if (beats_left > DUR_W'(1)) begin
                    beats_left <= beats_left - DUR_W'(1);
`ifdef NOTE_GAP_EN
                    // Reaching 1 by decrement implies the note had dur > 1
                    if (beats_left == DUR_W'(2)) note_active <= 1'b0;
`else
                    note_active <= note_active;
`endif
                end
            end
            if (state == DONE && !play_state[1]) begin
                pitch_out <= '0;
                last_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beat_note_timer.sv
// Directed bench for beat_note_timer.
// Expected values are hand-computed per vector.
module tb_beat_note_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] play_state;
    logic       beat;
    logic       note_valid;
    logic       note_ready;
    logic [5:0] note_pitch;
    logic [5:0] note_dur;
    logic       note_last;
    logic       beat_en;
    logic [5:0] pitch_out;
    logic       note_active;
    logic       new_note;
    logic [5:0] beats_left;
    logic       song_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    beat_note_timer #(.PITCH_W(6), .DUR_W(6)) dut (
        .clk(clk),
        .reset(reset),
        .play_state(play_state),
        .beat(beat),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_pitch(note_pitch),
        .note_dur(note_dur),
        .note_last(note_last),
        .beat_en(beat_en),
        .pitch_out(pitch_out),
        .note_active(note_active),
        .new_note(new_note),
        .beats_left(beats_left),
        .song_done(song_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic offer(input logic [5:0] p, input logic [5:0] d,
                         input logic l);
        note_valid = 1'b1;
        note_pitch = p;
        note_dur   = d;
        note_last  = l;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pitch"}, pitch_out, 0);
        check({tag, "_left"}, beats_left, 0);
        check({tag, "_act"}, note_active, 0);
        check({tag, "_rdy"}, note_ready, 0);
        check({tag, "_ben"}, beat_en, 0);
        check({tag, "_new"}, new_note, 0);
        check({tag, "_done"}, song_done, 0);
    endtask

    initial begin
        reset = 1'b0;
        play_state = 2'b00;
        beat = 1'b0;
        note_valid = 1'b0;
        note_pitch = '0;
        note_dur = '0;
        note_last = 1'b0;
        tick();
        tick();
        check_all_zero("rst");
        reset = 1'b1;
        tick();
        check("idle_rdy", note_ready, 0);

        // basic note
        play_state = 2'b10;
        tick();
        check("fetch_rdy", note_ready, 1);
        offer(6'd12, 6'd3, 1'b0);
        tick();
        note_valid = 1'b0;
        check("n1_new", new_note, 1);
        check("n1_pitch", pitch_out, 12);
        check("n1_left", beats_left, 3);
        check("n1_act", note_active, 1);
        check("n1_rdy", note_ready, 0);
        check("n1_ben", beat_en, 1);
        tick();
        check("n1_new_off", new_note, 0);
        pulse_beat();
        check("n1_b1", beats_left, 2);
        pulse_beat();
        check("n1_b2", beats_left, 1);
        pulse_beat();
        check("n1_b3", beats_left, 0);
        check("n1_act_end", note_active, 0);
        check("n1_rdy_end", note_ready, 1);
        check("n1_hold", pitch_out, 12);

        // two notes, last ends song
        offer(6'd5, 6'd2, 1'b0);
        tick();
        check("n2_new", new_note, 1);
        check("n2_pitch", pitch_out, 5);
        offer(6'd7, 6'd1, 1'b1);
        tick();
        check("n2_noxfer", pitch_out, 5);
        pulse_beat();
        check("n2_b1", beats_left, 1);
        pulse_beat();
        check("n2_b2", beats_left, 0);
        check("n2_rdy", note_ready, 1);
        tick();
        note_valid = 1'b0;
        check("n3_new", new_note, 1);
        check("n3_pitch", pitch_out, 7);
        check("n3_left", beats_left, 1);
        pulse_beat();
        check("n3_done", song_done, 1);
        check("n3_left0", beats_left, 0);
        tick();
        check("n3_done_off", song_done, 0);
        check("done_rdy", note_ready, 0);
        check("done_ben", beat_en, 0);
        play_state = 2'b00;
        tick();
        check_all_zero("idle2");

        // pause mid-note
        play_state = 2'b10;
        tick();
        offer(6'd20, 6'd6, 1'b0);
        tick();
        note_valid = 1'b0;
        check("p_left", beats_left, 6);
        pulse_beat();
        pulse_beat();
        check("p_left4", beats_left, 4);
        play_state = 2'b00;
        #1;
        check("p_ben", beat_en, 0);
        pulse_beat();
        pulse_beat();
        pulse_beat();
        check("p_hold", beats_left, 4);
        play_state = 2'b11;
        #1;
        check("p_ben_ff", beat_en, 1);
        pulse_beat();
        check("p_resume", beats_left, 3);
        play_state = 2'b10;
        pulse_beat();
        pulse_beat();
        pulse_beat();
        check("p_end", beats_left, 0);
        check("p_rdy", note_ready, 1);

        // zero-duration notes
        offer(6'd3, 6'd0, 1'b0);
        tick();
        check("z_new", new_note, 0);
        check("z_rdy", note_ready, 1);
        check("z_pitch", pitch_out, 20);
        offer(6'd4, 6'd2, 1'b0);
        tick();
        note_valid = 1'b0;
        check("z2_new", new_note, 1);
        check("z2_left", beats_left, 2);
        pulse_beat();
        pulse_beat();
        check("z2_end", note_ready, 1);
        offer(6'd8, 6'd0, 1'b1);
        tick();
        note_valid = 1'b0;
        check("z3_done", song_done, 1);
        check("z3_new", new_note, 0);
        check("z3_rdy", note_ready, 0);
        play_state = 2'b00;
        tick();

        // rest note, then async reset mid-note
        play_state = 2'b10;
        tick();
        offer(6'd0, 6'd2, 1'b0);
        tick();
        note_valid = 1'b0;
        check("r_new", new_note, 1);
        check("r_act", note_active, 0);
        check("r_left", beats_left, 2);
        pulse_beat();
        check("r_left1", beats_left, 1);
        check("r_act1", note_active, 0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("arst");
        tick();
        reset = 1'b1;

        // articulation gap
        tick();
        check("g_rdy", note_ready, 1);
        offer(6'd9, 6'd3, 1'b0);
        tick();
        note_valid = 1'b0;
        check("g_act3", note_active, 1);
        pulse_beat();
        check("g_act2", note_active, 1);
        pulse_beat();
        check("g_left1", beats_left, 1);
`ifdef NOTE_GAP_EN
        check("g_act1", note_active, 0);
`else
        check("g_act1", note_active, 1);
`endif
        check("g_pitch", pitch_out, 9);
        pulse_beat();
        check("g_act0", note_active, 0);
        check("g_left0", beats_left, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beat_note_timer.md
Name: beat_note_timer

Overview:
- Consumer end of the beat pulse: counts incoming `beat` pulses against each note's duration.
- Fetches notes from the song reader over a valid/ready handshake and presents the current pitch to the note player.
- Drives the enable for the upstream beat generator and flags end of song.
- Sits between the song ROM reader, the beat generator and the note player.

Parameters:
- PITCH_W, 6, width of the note pitch code; pitch 0 = rest.
- DUR_W, 6, width of the note duration in beats.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset (0 = reset).
- play_state  input  2  bit1 = play, bit0 = fast-forward; 2'b0x = paused.
- beat  input  1  one-cycle beat pulse from the beat generator.
- note_valid  input  1  song reader has a note on note_* inputs.
- note_ready  output  1  this block accepts a note this cycle.
- note_pitch  input  PITCH_W  pitch of the offered note.
- note_dur  input  DUR_W  duration in beats of the offered note.
- note_last  input  1  offered note is the final note of the song.
- beat_en  output  1  enable to the beat generator.
- pitch_out  output  PITCH_W  current pitch to the note player.
- note_active  output  1  current note is sounding.
- new_note  output  1  one-cycle pulse when a new note starts.
- beats_left  output  DUR_W  remaining beats of the current note.
- song_done  output  1  one-cycle pulse when the final note finishes.

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - All outputs 0: pitch_out=0, beats_left=0, note_active=0, note_ready=0, beat_en=0, new_note=0, song_done=0.
  - last flag cleared.
  - Reset mid-note abandons the note immediately; no song_done.
- States: IDLE, FETCH, PLAY, DONE. All state and outputs are registered, except note_ready and beat_en, which are decoded from state.
- IDLE:
  - note_ready=0, beat_en=0.
  - play_state[1]=1 -> FETCH next cycle.
- FETCH:
  - note_ready=1, beat_en=0.
  - Transfer occurs on the cycle with note_valid & note_ready.
  - Transfer with note_dur!=0: latch pitch, dur and last; go to PLAY.
  - The cycle after transfer: pitch_out=note_pitch, beats_left=note_dur, new_note=1 for exactly one cycle, note_active=(pitch!=0).
  - Transfer with note_dur==0: note discarded, no new_note. Stay in FETCH, or go to DONE if note_last=1.
  - play_state[1]=0 while in FETCH: stay in FETCH with note_ready held 1. The handshake is not gated by pause.
- PLAY:
  - beat_en = play_state[1]; fast-forward is handled by the beat generator.
  - A beat is counted only when beat=1 and play_state[1]=1; beats while paused are ignored.
  - Counted beat with beats_left>1: decrement beats_left by 1.
  - Counted beat with beats_left==1: beats_left=0 and note_active=0 next cycle. Go to DONE if the last flag is set, else to FETCH.
  - pitch_out holds its value until the next transfer.
  - beats_left never wraps below 0.
- DONE:
  - song_done=1 for exactly the first cycle in DONE.
  - note_ready=0, beat_en=0.
  - Stay in DONE while play_state[1]=1; play_state[1]=0 -> IDLE. A new play press restarts fetching.
- Simultaneous events:
  - beat in FETCH is ignored.
  - beat in the same cycle as the PLAY entry transition is ignored; counting starts the cycle after new_note.
- Whole-song latency: the final counted beat of the last note -> song_done exactly 1 cycle later.

Optional Feature:
- Macro: NOTE_GAP_EN.
- Defined: during PLAY, for notes latched with dur>1, note_active is forced to 0 while beats_left==1. This gives an audible articulation gap in the final beat of the note. pitch_out is unchanged.
- Undefined: note_active stays (pitch!=0) for the whole note.
- Counting and handshake are identical either way.

Test Plan:
- Reset, then play_state=2'b10 -> FETCH and note_ready=1 on the 2nd cycle. Offer pitch=12, dur=3, last=0 -> new_note pulse, pitch_out=12, beats_left=3, note_active=1. After 3 beats -> beats_left=0 and note_ready=1 again.
- Note pitch=5, dur=2, then last note pitch=7, dur=1, last=1 -> after 3 total counted beats, song_done pulses once. play_state=0 -> IDLE, all outputs 0.
- Mid-note with beats_left=4, play_state=2'b00 and 3 beat pulses applied -> beats_left stays 4 and beat_en=0. Resume play -> counting continues from 4.
- Offer dur=0 (last=0), then dur=2 -> first note dropped with no new_note; second plays for 2 beats. Offer dur=0 with last=1 -> DONE and song_done.
- Pitch=0 (rest), dur=2 -> note_active=0 throughout, beats still counted. Assert reset mid-note -> all outputs 0 immediately, asynchronously.
- With NOTE_GAP_EN, pitch=9, dur=3 -> note_active=1 for beats_left 3 and 2, 0 for beats_left 1. Without the macro -> note_active=1 for all 3 beats.
